regfile_seq_tester: RTL and testbench

- Parametrised self-checking instruction sequencer that drives the datapath with a Fibonacci fill of the register file.
- Generalises the fixed 31-state register-file test FSM: register count, data width and seed are parameters.
- Adds a start/busy/done handshake, a valid/ready issue handshake so the datapath can stall, and optional result checking.
- Sits between the board/test top and the datapath. The 7-seg display logic stays outside and reads last_value.

---
 rtl/regfile_seq_tester_if.sv | 24 ++
 rtl/regfile_seq_tester.sv | 187 ++++++++++++++++++
 tb/tb_regfile_seq_tester.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_seq_tester_if.sv
// Instruction issue / result return port between the sequencer and the datapath.
// The sequencer is the master: it drives instr/instr_valid and consumes instr_ready/result.
interface regfile_seq_tester_if #(
  parameter int unsigned DATA_WIDTH = 16
) ();
  logic [15:0]           instr;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] result;

  modport master (
    output instr,
    output instr_valid,
    input  instr_ready,
    input  result
  );

  modport slave (
    input  instr,
    input  instr_valid,
    output instr_ready,
    output result
  );
endinterface

// File: rtl/regfile_seq_tester.sv
// Sequencer that fills the datapath register file with a Fibonacci series over a valid/ready port.
// Define SEQ_CHECK_EN to compile in the expected-value tracker and the sticky mismatch report.
module regfile_seq_tester #(
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter logic [7:0]  SEED       = 8'd1,
  parameter int unsigned RESULT_LAT = 1,
  parameter int unsigned STEP_W     = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  regfile_seq_tester_if.master  dp,
  output logic                  busy,
  output logic                  done,
  output logic [STEP_W-1:0]     step,
  output logic [DATA_WIDTH-1:0] last_value,
  output logic                  error,
  output logic [STEP_W-1:0]     err_step
);

  localparam int unsigned       TOTAL     = 2 + 2 * (NUM_REGS - 2);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(TOTAL - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic [2:0]            lat_q, lat_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] last_q, last_d;

  logic                  start_seq;
  logic                  sample;
  logic [3:0]            k;
  logic [15:0]           instr_word;

  assign start_seq = start && ((state_q == StIdle) || (state_q == StDone));
  assign sample    = (state_q == StWait) && (lat_q <= 3'd1);

  // Steps 2k-2 / 2k-1 both target rk, so k comes straight from the step index.
  assign k = 4'((step_q >> 1) + STEP_W'(1));

  always_comb begin
    instr_word = 16'h0000;
    if (step_q == STEP_W'(0)) begin
      instr_word = {4'b0101, 4'd0, SEED};
    end else if (step_q == STEP_W'(1)) begin
      instr_word = {4'b0101, 4'd1, SEED};
    end else if (!step_q[0]) begin
      instr_word = {4'b0000, k, 4'b1101, k - 4'd1};
    end else begin
      instr_word = {4'b0000, k, 4'b0101, k - 4'd2};
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    lat_d   = lat_q;
    done_d  = done_q;
    last_d  = last_q;
    case (state_q)
      StIdle, StDone: begin
        if (start_seq) begin
          step_d  = '0;
          done_d  = 1'b0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (dp.instr_ready) begin
          lat_d   = 3'(RESULT_LAT);
          state_d = StWait;
        end
      end
      StWait: begin
        lat_d = lat_q - 3'd1;
        if (sample) begin
          last_d = dp.result;
          if (step_q == LAST_STEP) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            step_d  = step_q + STEP_W'(1);
            state_d = StIssue;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      step_q  <= '0;
      lat_q   <= '0;
      done_q  <= 1'b0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      lat_q   <= lat_d;
      done_q  <= done_d;
      last_q  <= last_d;
    end
  end

  // instr is forced to zero outside ISSUE so every output reads 0 after reset.
  assign dp.instr_valid = (state_q == StIssue);
  assign dp.instr       = dp.instr_valid ? instr_word : 16'h0000;
  assign busy           = (state_q == StIssue) || (state_q == StWait);
  assign done           = done_q;
  assign step           = step_q;
  assign last_value     = last_q;

`ifdef SEQ_CHECK_EN
  logic [DATA_WIDTH-1:0] prev1_q, prev1_d;
  logic [DATA_WIDTH-1:0] prev2_q, prev2_d;
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] exp_val;
  logic                  error_q, error_d;
  logic [STEP_W-1:0]     err_step_q, err_step_d;

  assign sum = prev1_q + prev2_q;

  always_comb begin
    if (step_q < STEP_W'(2)) begin
      exp_val = DATA_WIDTH'(SEED);
    end else if (step_q[0]) begin
      exp_val = sum;
    end else begin
      exp_val = prev1_q;
    end
  end

  always_comb begin
    prev1_d    = prev1_q;
    prev2_d    = prev2_q;
    error_d    = error_q;
    err_step_d = err_step_q;
    if (start_seq) begin
      prev1_d    = DATA_WIDTH'(SEED);
      prev2_d    = DATA_WIDTH'(SEED);
      error_d    = 1'b0;
      err_step_d = '0;
    end else if (sample) begin
      if (dp.result != exp_val) begin
        error_d = 1'b1;
        if (!error_q) begin
          err_step_d = step_q;
        end
      end
      // Only ADD steps advance the series; step 1 is the second seed load.
      if (step_q[0] && (step_q != STEP_W'(1))) begin
        prev2_d = prev1_q;
        prev1_d = sum;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev1_q    <= '0;
      prev2_q    <= '0;
      error_q    <= 1'b0;
      err_step_q <= '0;
    end else begin
      prev1_q    <= prev1_d;
      prev2_q    <= prev2_d;
      error_q    <= error_d;
      err_step_q <= err_step_d;
    end
  end

  assign error    = error_q;
  assign err_step = err_step_q;
`else
  assign error    = 1'b0;
  assign err_step = '0;
`endif

endmodule

// File: tb/tb_regfile_seq_tester.sv
// Directed bench for regfile_seq_tester: three instances (default, 8-bit data, 3 regs / latency 3)
// each driven by a small register-file datapath model.
module tb_regfile_seq_tester;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic ready0 = 1'b1;
  logic corrupt_en = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_seq_tester_if #(.DATA_WIDTH(16)) if0 ();
  regfile_seq_tester_if #(.DATA_WIDTH(8))  if1 ();
  regfile_seq_tester_if #(.DATA_WIDTH(16)) if2 ();

  logic        busy0, done0, error0, busy1, done1, error1, busy2, done2, error2;
  logic [5:0]  step0, err_step0, step1, err_step1, step2, err_step2;
  logic [15:0] last0, last2;
  logic [7:0]  last1;
  logic [15:0] res0 = 16'h0, res1 = 16'h0, res2 = 16'h0;
  logic [15:0] rf0 [16];
  logic [15:0] rf1 [16];
  logic [15:0] rf2 [16];
  logic [15:0] log0 [64];
  int          n0;

  regfile_seq_tester u0 (
    .clk(clk), .reset(rst_n), .start(start0), .dp(if0), .busy(busy0), .done(done0),
    .step(step0), .last_value(last0), .error(error0), .err_step(err_step0)
  );

  regfile_seq_tester #(.DATA_WIDTH(8)) u1 (
    .clk(clk), .reset(rst_n), .start(start1), .dp(if1), .busy(busy1), .done(done1),
    .step(step1), .last_value(last1), .error(error1), .err_step(err_step1)
  );

  regfile_seq_tester #(.NUM_REGS(3), .RESULT_LAT(3)) u2 (
    .clk(clk), .reset(rst_n), .start(start2), .dp(if2), .busy(busy2), .done(done2),
    .step(step2), .last_value(last2), .error(error2), .err_step(err_step2)
  );

  assign if0.instr_ready = ready0;
  assign if1.instr_ready = 1'b1;
  assign if2.instr_ready = 1'b1;
  assign if0.result = res0;
  assign if1.result = res1[7:0];
  assign if2.result = res2;

  // Datapath model: ADDI loads the zero-extended immediate, ext 1101 is MOV, ext 0101 is ADD.
  function automatic logic [15:0] alu(input logic [15:0] ins, input logic [15:0] rd,
                                      input logic [15:0] rs);
    if (ins[15:12] == 4'b0101) return {8'h00, ins[7:0]};
    if (ins[7:4] == 4'b1101) return rs;
    return rd + rs;
  endfunction

  always @(posedge clk) begin : model0
    logic [15:0] v;
    if (if0.instr_valid && if0.instr_ready) begin
      v = alu(if0.instr, rf0[if0.instr[11:8]], rf0[if0.instr[3:0]]);
      rf0[if0.instr[11:8]] <= v;
      res0 <= (corrupt_en && (if0.instr == 16'h0452 || if0.instr == 16'h07D6)) ? 16'h0 : v;
    end
  end

  always @(posedge clk) begin : model1
    logic [15:0] v;
    if (if1.instr_valid && if1.instr_ready) begin
      v = alu(if1.instr, rf1[if1.instr[11:8]], rf1[if1.instr[3:0]]);
      rf1[if1.instr[11:8]] <= v;
      res1 <= v;
    end
  end

  always @(posedge clk) begin : model2
    logic [15:0] v;
    if (if2.instr_valid && if2.instr_ready) begin
      v = alu(if2.instr, rf2[if2.instr[11:8]], rf2[if2.instr[3:0]]);
      rf2[if2.instr[11:8]] <= v;
      res2 <= v;
    end
  end

  function automatic logic [15:0] exp_instr(input int s);
    logic [3:0] k;
    k = 4'(s / 2 + 1);
    if (s == 0) return 16'h5001;
    if (s == 1) return 16'h5101;
    if (s % 2 == 0) return {4'h0, k, 4'hD, k - 4'd1};
    return {4'h0, k, 4'h5, k - 4'd2};
  endfunction

  // Runs one sequence on u0; optionally stalls step 5 for 3 cycles or pokes start at step 4.
  task automatic run0(input bit do_stall, input bit do_poke, output int cyc);
    int hold;
    bit stalled, poked, poke_chk;
    hold = 0; stalled = 0; poked = 0; poke_chk = 0; n0 = 0; ready0 = 1'b1;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0; cyc = 0;
    while (!done0 && cyc < 500) begin
      if (do_stall && !stalled && step0 == 6'd5 && if0.instr_valid) begin
        ready0 = 1'b0; stalled = 1; hold = 3;
      end
      if (do_poke && !poked && step0 == 6'd4 && if0.instr_valid) begin
        start0 = 1'b1; poked = 1; poke_chk = 1;
      end
      if (if0.instr_valid && ready0 && n0 < 64) begin
        log0[n0] = if0.instr; n0++;
      end
      @(posedge clk); #1; cyc++;
      start0 = 1'b0;
      if (poke_chk) begin
        poke_chk = 0;
        checks++;
        if (step0 !== 6'd4 || busy0 !== 1'b1) begin
          failures++;
          $display("FAIL poke_ignored: step=%0d busy=%b, want step=4 busy=1", step0, busy0);
        end
      end
      if (hold > 0) begin
        checks++;
        if (if0.instr !== 16'h0351 || step0 !== 6'd5 || if0.instr_valid !== 1'b1) begin
          failures++;
          $display("FAIL stall_hold: instr=%h step=%0d valid=%b, want 0351/5/1",
                   if0.instr, step0, if0.instr_valid);
        end
        hold--;
        if (hold == 0) ready0 = 1'b1;
      end
    end
    if (cyc >= 500) begin
      failures++;
      $display("FAIL run0_timeout: done never rose within 500 cycles");
    end
  endtask

  task automatic test_reset();
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || if0.instr_valid !== 1'b0 || step0 !== 6'd0) begin
      failures++;
      $display("FAIL reset_ctrl: busy=%b done=%b valid=%b step=%0d, want all 0",
               busy0, done0, if0.instr_valid, step0);
    end
    checks++;
    if (if0.instr !== 16'h0 || last0 !== 16'h0 || error0 !== 1'b0 || err_step0 !== 6'd0) begin
      failures++;
      $display("FAIL reset_data: instr=%h last=%h err=%b err_step=%0d, want all 0",
               if0.instr, last0, error0, err_step0);
    end
    checks++;
    if (busy1 !== 1'b0 || busy2 !== 1'b0 || last1 !== 8'h0 || last2 !== 16'h0) begin
      failures++;
      $display("FAIL reset_others: busy1=%b busy2=%b last1=%h last2=%h, want 0",
               busy1, busy2, last1, last2);
    end
  endtask

  task automatic test_sequence();
    int cyc;
    run0(1'b0, 1'b0, cyc);
    checks++;
    if (cyc !== 60) begin
      failures++; $display("FAIL seq_latency: cycles=%0d want 60", cyc);
    end
    checks++;
    if (last0 !== 16'h03DB) begin
      failures++; $display("FAIL seq_last_value: got %h want 03db", last0);
    end
    checks++;
    if (error0 !== 1'b0 || done0 !== 1'b1 || busy0 !== 1'b0) begin
      failures++;
      $display("FAIL seq_status: error=%b done=%b busy=%b want 0/1/0", error0, done0, busy0);
    end
    checks++;
    if (n0 !== 30) begin
      failures++; $display("FAIL seq_count: issued=%0d want 30", n0);
    end
    checks++;
    if (log0[2] !== 16'h02D1 || log0[29] !== 16'h0F5D) begin
      failures++;
      $display("FAIL seq_spot: step2=%h step29=%h want 02d1/0f5d", log0[2], log0[29]);
    end
    for (int s = 0; s < 30; s++) begin
      checks++;
      if (log0[s] !== exp_instr(s)) begin
        failures++;
        $display("FAIL seq_instr[%0d]: got %h want %h", s, log0[s], exp_instr(s));
      end
    end
  endtask

  task automatic test_stall();
    int cyc;
    run0(1'b1, 1'b0, cyc);
    checks++;
    if (cyc !== 63) begin
      failures++; $display("FAIL stall_latency: cycles=%0d want 63", cyc);
    end
    checks++;
    if (last0 !== 16'h03DB || error0 !== 1'b0 || n0 !== 30) begin
      failures++;
      $display("FAIL stall_result: last=%h err=%b issued=%0d want 03db/0/30", last0, error0, n0);
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    run0(1'b0, 1'b1, cyc);
    checks++;
    if (cyc !== 60 || last0 !== 16'h03DB) begin
      failures++;
      $display("FAIL start_ignored: cycles=%0d last=%h want 60/03db", cyc, last0);
    end
  endtask

  task automatic test_mismatch();
    int cyc;
    logic       exp_err;
    logic [5:0] exp_es;
`ifdef SEQ_CHECK_EN
    exp_err = 1'b1; exp_es = 6'd7;
`else
    exp_err = 1'b0; exp_es = 6'd0;
`endif
    corrupt_en = 1'b1;
    run0(1'b0, 1'b0, cyc);
    corrupt_en = 1'b0;
    checks++;
    if (error0 !== exp_err || err_step0 !== exp_es) begin
      failures++;
      $display("FAIL mismatch_flag: error=%b err_step=%0d want %b/%0d",
               error0, err_step0, exp_err, exp_es);
    end
    checks++;
    if (done0 !== 1'b1 || cyc !== 60 || n0 !== 30 || last0 !== 16'h03DB) begin
      failures++;
      $display("FAIL mismatch_complete: done=%b cycles=%0d issued=%0d last=%h",
               done0, cyc, n0, last0);
    end
  endtask

  task automatic test_restart();
    int cyc;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    checks++;
    if (done0 !== 1'b0 || busy0 !== 1'b1 || step0 !== 6'd0 || if0.instr !== 16'h5001) begin
      failures++;
      $display("FAIL restart: done=%b busy=%b step=%0d instr=%h want 0/1/0/5001",
               done0, busy0, step0, if0.instr);
    end
    checks++;
    if (error0 !== 1'b0 || err_step0 !== 6'd0) begin
      failures++;
      $display("FAIL restart_clear: error=%b err_step=%0d want 0/0", error0, err_step0);
    end
    cyc = 0;
    while (!done0 && cyc < 500) begin
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (cyc !== 60 || error0 !== 1'b0) begin
      failures++; $display("FAIL restart_run: cycles=%0d error=%b want 60/0", cyc, error0);
    end
  endtask

  task automatic test_midreset();
    int cyc;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0; cyc = 0;
    while (step0 != 6'd10 && cyc < 500) begin
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (step0 !== 6'd10) begin
      failures++; $display("FAIL midreset_reach: step=%0d want 10", step0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy0 !== 1'b0 || if0.instr_valid !== 1'b0 || step0 !== 6'd0 || done0 !== 1'b0 ||
        error0 !== 1'b0) begin
      failures++;
      $display("FAIL midreset_abort: busy=%b valid=%b step=%0d done=%b error=%b want 0",
               busy0, if0.instr_valid, step0, done0, error0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    checks++;
    if (step0 !== 6'd0 || if0.instr !== 16'h5001 || if0.instr_valid !== 1'b1) begin
      failures++;
      $display("FAIL midreset_restart: step=%0d instr=%h valid=%b want 0/5001/1",
               step0, if0.instr, if0.instr_valid);
    end
    cyc = 0;
    while (!done0 && cyc < 500) begin
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (last0 !== 16'h03DB) begin
      failures++; $display("FAIL midreset_last: got %h want 03db", last0);
    end
  endtask

  task automatic test_width8();
    int  cyc;
    bit  seen;
    seen = 0;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0; cyc = 0;
    while (!done1 && cyc < 500) begin
      @(posedge clk); #1; cyc++;
      if (!seen && step1 == 6'd26) begin
        seen = 1;
        checks++;
        if (last1 !== 8'h79 || error1 !== 1'b0) begin
          failures++;
          $display("FAIL w8_step25: last=%h error=%b want 79/0", last1, error1);
        end
      end
    end
    checks++;
    if (cyc !== 60 || last1 !== 8'hDB || error1 !== 1'b0 || !seen) begin
      failures++;
      $display("FAIL w8_final: cycles=%0d last=%h error=%b seen=%b want 60/db/0/1",
               cyc, last1, error1, seen);
    end
  endtask

  task automatic test_small();
    int cyc;
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0; cyc = 0;
    while (!done2 && cyc < 500) begin
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (cyc !== 16) begin
      failures++; $display("FAIL small_latency: cycles=%0d want 16", cyc);
    end
    checks++;
    if (last2 !== 16'h0002 || error2 !== 1'b0 || step2 !== 6'd3) begin
      failures++;
      $display("FAIL small_result: last=%h error=%b step=%0d want 0002/0/3",
               last2, error2, step2);
    end
  endtask

  initial begin
    #1;
    test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_sequence();
    test_stall();
    test_start_ignored();
    test_mismatch();
    test_restart();
    test_midreset();
    test_width8();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
